jk_register_bank: RTL

Parametrised WIDTH-bit register built from per-bit JK cells with asynchronous active-low reset. It supports per-bit JK operation, synchronous up and down counting (internal toggle vectors), and parallel load. Registered wrap and change flags are provided. It is the general-purpose successor to the single-bit JK flip-flop and is used wherever the sequential library needs a JK-style multi-bit state register or a small counter.

---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_cell.sv | 34 +++
 rtl/jk_register_bank.sv | 130 +++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for JK-style sequential blocks: mode encodings and the
// per-cell JK action encoding with its next-state helper.
package jk_pkg;

   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_UP = 2'b01;
   localparam logic [1:0] MODE_DN = 2'b10;
   localparam logic [1:0] MODE_LD = 2'b11;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_CLR  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_action_e;

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic nxt;
      case (jk_action_e'({j, k}))
         JK_HOLD: nxt = q;
         JK_CLR:  nxt = 1'b0;
         JK_SET:  nxt = 1'b1;
         JK_TGL:  nxt = ~q;
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with asynchronous active-low reset to a
// parameterised value.
module jk_cell
   import jk_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_d;
   logic q_q;

   // Next-state from the JK action table
   always_comb begin
      q_d = jk_next(q_q, j, k);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit register of JK cells: per-bit JK, up/down counting via toggle
// chains, and parallel load, with registered wrap and change flags.
module jk_register_bank
   import jk_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             chg
);

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] t_up_s;
   logic [WIDTH-1:0] t_dn_s;
   logic             run_up_s;
   logic             run_dn_s;
   logic [WIDTH-1:0] j_eff_s;
   logic [WIDTH-1:0] k_eff_s;
   logic [WIDTH-1:0] q_nxt_s;
   logic             wrap_d;
   logic             wrap_q;
   logic             chg_d;
   logic             chg_q;

   // Toggle chains: bit i toggles when all lower bits are ones (up) or zeros (down)
   always_comb begin
      t_up_s   = {WIDTH{1'b0}};
      t_dn_s   = {WIDTH{1'b0}};
      run_up_s = 1'b1;
      run_dn_s = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         t_up_s[i] = run_up_s;
         t_dn_s[i] = run_dn_s;
         run_up_s  = run_up_s & q_s[i];
         run_dn_s  = run_dn_s & ~q_s[i];
      end
   end

   // Mode decode into effective J/K vectors; disabled means hold everywhere
   always_comb begin
      j_eff_s = {WIDTH{1'b0}};
      k_eff_s = {WIDTH{1'b0}};
      if (en) begin
         case (mode)
            MODE_JK: begin
               j_eff_s = j;
               k_eff_s = k;
            end
            MODE_UP: begin
               j_eff_s = t_up_s;
               k_eff_s = t_up_s;
            end
            MODE_DN: begin
               j_eff_s = t_dn_s;
               k_eff_s = t_dn_s;
            end
            MODE_LD: begin
               j_eff_s = d;
               k_eff_s = ~d;
            end
            default: begin
               j_eff_s = {WIDTH{1'b0}};
               k_eff_s = {WIDTH{1'b0}};
            end
         endcase
      end else begin
         j_eff_s = {WIDTH{1'b0}};
         k_eff_s = {WIDTH{1'b0}};
      end
   end

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_cell
         jk_cell #(
            .RESET_VAL (RESET_VAL[g])
         ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_eff_s[g]),
            .k     (k_eff_s[g]),
            .q     (q_s[g])
         );
      end
   endgenerate

   // Predicted next q (mirrors the cells) and the wrap condition for the flags
   always_comb begin
      q_nxt_s = q_s;
      for (int i = 0; i < WIDTH; i++) begin
         q_nxt_s[i] = jk_next(q_s[i], j_eff_s[i], k_eff_s[i]);
      end
      chg_d  = (q_nxt_s != q_s);
      wrap_d = 1'b0;
      if (en) begin
         case (mode)
            MODE_UP: wrap_d = &q_s;
            MODE_DN: wrap_d = ~|q_s;
            default: wrap_d = 1'b0;
         endcase
      end else begin
         wrap_d = 1'b0;
      end
   end

   // Flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
         chg_q  <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
         chg_q  <= chg_d;
      end
   end

   assign q    = q_s;
   assign wrap = wrap_q;
   assign chg  = chg_q;

endmodule
